// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encodings and datapath widths for the alu request sequencer.
package alu_seq_pkg;

    localparam int OPND_W = 64;
    localparam int RES_W  = 128;

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_CLR = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Every opcode except NOP goes through the alu and yields a completion pulse.
    function automatic logic op_uses_alu(input logic [1:0] op);
        return op != OP_NOP;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response handshake bundle between a client (master) and the sequencer (slave).
interface alu_seq_ctrl_if #(
    parameter int TAG_W = 4
);
    import alu_seq_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [OPND_W-1:0] req_a;
    logic [OPND_W-1:0] req_b;
    logic [1:0]        req_op;
    logic [TAG_W-1:0]  req_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [RES_W-1:0]  rsp_c;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_c, rsp_tag, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_c, rsp_tag, rsp_err
    );

endinterface

// File: rtl/alu_req_fifo.sv
// Small synchronous FIFO with registered full/empty flags; head entry is read combinationally.
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Flags come from registers, so a same-cycle pop does not reopen a full FIFO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Request sequencer in front of the pipelined alu: queues requests, issues one at a time, returns tagged results.
// Optional WAIT watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic              clk,
    input  logic              resetn,
    alu_seq_ctrl_if.slave     bus,
    output logic [OPND_W-1:0] alu_a_o,
    output logic [OPND_W-1:0] alu_b_o,
    output logic [1:0]        alu_op_o,
    input  logic [RES_W-1:0]  alu_c_i,
    input  logic              alu_done_i,
    output logic              busy_o
);
    localparam int ENT_W = TAG_W + 2 + 2*OPND_W;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [ENT_W-1:0]  head;
    logic [TAG_W-1:0]  head_tag;
    logic [1:0]        head_op;
    logic [OPND_W-1:0] head_a;
    logic [OPND_W-1:0] head_b;

    logic [1:0]        state_q,   state_d;
    logic [OPND_W-1:0] alu_a_q,   alu_a_d;
    logic [OPND_W-1:0] alu_b_q,   alu_b_d;
    logic [1:0]        alu_op_q,  alu_op_d;
    logic [RES_W-1:0]  rsp_c_q,   rsp_c_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic              tmo_hit;

    assign {head_tag, head_op, head_a, head_b} = head;

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (bus.req_valid),
        .din_i   ({bus.req_tag, bus.req_op, bus.req_a, bus.req_b}),
        .pop_i   (fifo_pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        rsp_c_d   = rsp_c_q;
        rsp_tag_d = rsp_tag_q;
        fifo_pop  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    rsp_tag_d = head_tag;
                    if (op_uses_alu(head_op)) begin
                        alu_a_d  = head_a;
                        alu_b_d  = head_b;
                        alu_op_d = head_op;
                        state_d  = S_ISSUE;
                    end else begin
                        // NOP never reaches the alu; answer immediately with zero.
                        rsp_c_d = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                alu_op_d = OP_NOP;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (alu_done_i) begin
                    rsp_c_d = alu_c_i;
                    state_d = S_RESP;
                end else if (tmo_hit) begin
                    rsp_c_d = '0;
                    state_d = S_RESP;
                end
            end
            default: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= OP_NOP;
            rsp_c_q   <= '0;
            rsp_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            rsp_c_q   <= rsp_c_d;
            rsp_tag_q <= rsp_tag_d;
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_err_q, rsp_err_d;

    // Counter restarts on every entry to WAIT; it reads k after k cycles spent there.
    assign tmo_hit = (state_q == S_WAIT) && !alu_done_i &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_cnt_d = (state_q == S_WAIT) ? tmo_cnt_q + CNT_W'(1) : '0;
        rsp_err_d = rsp_err_q;
        if (tmo_hit) begin
            rsp_err_d = 1'b1;
        end else if (state_q == S_RESP && bus.rsp_ready) begin
            rsp_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = ~fifo_full;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_c     = rsp_c_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign alu_a_o       = alu_a_q;
    assign alu_b_o       = alu_b_q;
    assign alu_op_o      = alu_op_q;
    assign busy_o        = (state_q != S_IDLE) | ~fifo_empty;

endmodule
